// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the iterative ALU:
//   - Func3 op-code encodings
//   - FSM state encoding (IDLE / SHIFT / DONE)
//   - Bit positions of the {V,C,Z,N} Status vector
//   - is_shift(): true for the two shift op-codes
`timescale 1ns/1ps
package alu_pkg;

    localparam logic [2:0] FUNC_ADD = 3'b000;
    localparam logic [2:0] FUNC_SUB = 3'b001;
    localparam logic [2:0] FUNC_AND = 3'b010;
    localparam logic [2:0] FUNC_OR  = 3'b011;
    localparam logic [2:0] FUNC_NOR = 3'b100;
    localparam logic [2:0] FUNC_XOR = 3'b101;
    localparam logic [2:0] FUNC_SRL = 3'b110;
    localparam logic [2:0] FUNC_SLL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int STAT_V = 3;
    localparam int STAT_C = 2;
    localparam int STAT_Z = 1;
    localparam int STAT_N = 0;

    function automatic logic is_shift(input logic [2:0] func);
        return (func == FUNC_SRL) || (func == FUNC_SLL);
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// alu_addsub
//   Combinational adder/subtractor with carry-out and signed-overflow flags.
//   Subtraction is A + ~B + 1, so carry=1 means "no borrow".
// Ports
//   a, b      in  [WIDTH-1:0]  operands
//   sub       in  1            0: a+b, 1: a-b
//   sum       out [WIDTH-1:0]  result modulo 2^WIDTH
//   carry     out 1            carry out of the msb
//   overflow  out 1            signed overflow
`timescale 1ns/1ps
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH-1:0] b_eff;

    // Subtraction reuses the adder: invert B and inject the +1 as carry-in.
    // Overflow on the effective operand covers both ADD and SUB: inputs of
    // equal sign producing a result of the other sign.
    always_comb begin
        b_eff            = sub ? ~b : b;
        {carry, sum}     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
        overflow         = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/alu_iter.sv
// alu_iter
//   Handshaked ALU. Operands are latched on an InValid/InReady accept; the
//   result and {V,C,Z,N} flags are presented on OutValid/OutReady.
//   Add/sub/logic ops finish in one cycle; shifts iterate one bit per cycle
//   unless FAST_SHIFT=1, in which case a barrel shift finishes in one cycle.
// Ports
//   Clk, Rst_n         clock, asynchronous active-low reset
//   InValid/InReady    input handshake; InReady is combinational
//   Func3              op-code (see alu_pkg)
//   DataA, DataB       operands; shifts use DataB[SHW-1:0]
//   OutValid/OutReady  output handshake
//   ResultC, Status    registered result and {V,C,Z,N}
`timescale 1ns/1ps
module alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit FAST_SHIFT = 1'b0
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             InValid,
    output logic             InReady,
    input  logic [2:0]       Func3,
    input  logic [WIDTH-1:0] DataA,
    input  logic [WIDTH-1:0] DataB,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] ResultC,
    output logic [3:0]       Status
);

    localparam int SHW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [2:0]       func_q, func_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       status_q, status_d;

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] addsub_sum;
    logic             addsub_c, addsub_v;
    logic [WIDTH:0]   srl_ext, sll_ext;
    logic [WIDTH-1:0] op_res, step_res;
    logic             op_c, op_v, step_c;
    logic             accept, go_shift;

    assign shamt = DataB[SHW-1:0];

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a        (DataA),
        .b        (DataB),
        .sub      (Func3 == FUNC_SUB),
        .sum      (addsub_sum),
        .carry    (addsub_c),
        .overflow (addsub_v)
    );

    // One extra guard bit on each barrel shift captures the last bit shifted
    // out; with a shift amount of zero the guard bit stays 0, so C=0.
    assign srl_ext = {DataA, 1'b0} >> shamt;
    assign sll_ext = {1'b0, DataA} << shamt;

    // Single-cycle result and V/C for the op presented at the input.
    always_comb begin
        op_res = addsub_sum;
        op_c   = 1'b0;
        op_v   = 1'b0;
        case (Func3)
            FUNC_ADD, FUNC_SUB: begin
                op_res = addsub_sum;
                op_c   = addsub_c;
                op_v   = addsub_v;
            end
            FUNC_AND: op_res = DataA & DataB;
            FUNC_OR:  op_res = DataA | DataB;
            FUNC_NOR: op_res = ~(DataA | DataB);
            FUNC_XOR: op_res = DataA ^ DataB;
            FUNC_SRL: begin
                op_res = srl_ext[WIDTH:1];
                op_c   = srl_ext[0];
            end
            default: begin
                op_res = sll_ext[WIDTH-1:0];
                op_c   = sll_ext[WIDTH];
            end
        endcase
    end

    // One iterative shift step on the accumulator (held in result_q).
    always_comb begin
        step_res = result_q;
        step_c   = 1'b0;
        if (func_q == FUNC_SRL) begin
            {step_res, step_c} = {1'b0, result_q};
        end else begin
            {step_c, step_res} = {result_q, 1'b0};
        end
    end

    assign InReady  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && OutReady);
    assign OutValid = (state_q == ST_DONE);
    assign ResultC  = result_q;
    assign Status   = status_q;

    assign accept   = InValid && InReady;
    assign go_shift = is_shift(Func3) && !FAST_SHIFT && (shamt != '0);

    // Next-state logic. An accept can only happen in IDLE or DONE, so it
    // overrides the DONE->IDLE retire and never collides with a SHIFT step.
    always_comb begin
        state_d  = state_q;
        func_d   = func_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        status_d = status_q;

        case (state_q)
            ST_IDLE: ;
            ST_SHIFT: begin
                result_d         = step_res;
                status_d         = '0;
                status_d[STAT_C] = step_c;
                status_d[STAT_Z] = (step_res == '0);
                status_d[STAT_N] = step_res[WIDTH-1];
                cnt_d            = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (OutReady) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            func_d = Func3;
            if (go_shift) begin
                state_d  = ST_SHIFT;
                result_d = DataA;
                cnt_d    = shamt;
                status_d = '0;
            end else begin
                state_d          = ST_DONE;
                result_d         = op_res;
                status_d[STAT_V] = op_v;
                status_d[STAT_C] = op_c;
                status_d[STAT_Z] = (op_res == '0);
                status_d[STAT_N] = op_res[WIDTH-1];
            end
        end
    end

    // State registers; reset drops any op in flight.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= ST_IDLE;
            func_q   <= FUNC_ADD;
            cnt_q    <= '0;
            result_q <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            func_q   <= func_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            status_q <= status_d;
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter
//   Self-checking bench for alu_iter (WIDTH=32). The main instance uses
//   iterative shifts and is checked through an expected-result queue; a
//   second FAST_SHIFT=1 instance checks single-cycle shifts directly.
`timescale 1ns/1ps
module tb_alu_iter;

    logic        Clk;
    logic        Rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  func3;
    logic [31:0] data_a, data_b, result_c;
    logic [3:0]  status;

    logic        f_in_valid, f_in_ready, f_out_valid, f_out_ready;
    logic [2:0]  f_func3;
    logic [31:0] f_data_a, f_data_b, f_result_c;
    logic [3:0]  f_status;

    int          test_count = 0;
    int          fail_count = 0;
    logic [35:0] exp_q[$];
    bit          rand_bp    = 1'b0;

    alu_iter #(.WIDTH(32), .FAST_SHIFT(1'b0)) u_dut (
        .Clk(Clk), .Rst_n(Rst_n), .InValid(in_valid), .InReady(in_ready),
        .Func3(func3), .DataA(data_a), .DataB(data_b), .OutValid(out_valid),
        .OutReady(out_ready), .ResultC(result_c), .Status(status)
    );

    alu_iter #(.WIDTH(32), .FAST_SHIFT(1'b1)) u_fast (
        .Clk(Clk), .Rst_n(Rst_n), .InValid(f_in_valid), .InReady(f_in_ready),
        .Func3(f_func3), .DataA(f_data_a), .DataB(f_data_b), .OutValid(f_out_valid),
        .OutReady(f_out_ready), .ResultC(f_result_c), .Status(f_status)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: returns {V,C,Z,N, result}.
    function automatic logic [35:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] t;
        logic [31:0] r;
        logic        v, c;
        int          sh;
        sh = int'(b[4:0]);
        v  = 1'b0;
        c  = 1'b0;
        r  = '0;
        case (f)
            3'b000: begin
                t = {1'b0, a} + {1'b0, b};
                r = t[31:0]; c = t[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'b001: begin
                t = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = t[31:0]; c = t[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'b010: r = a & b;
            3'b011: r = a | b;
            3'b100: r = ~(a | b);
            3'b101: r = a ^ b;
            3'b110: begin
                r = a >> sh;
                c = (sh == 0) ? 1'b0 : a[sh-1];
            end
            default: begin
                r = a << sh;
                c = (sh == 0) ? 1'b0 : a[32-sh];
            end
        endcase
        return {v, c, (r == 32'd0), r[31], r};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        test_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Presents one op and waits (bounded) for the accept edge; the expected
    // result is queued at the sample point just before that edge.
    task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int  wait_cycles = 0;
        bit  done        = 1'b0;
        func3    = f;
        data_a   = a;
        data_b   = b;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge Clk);
            if (in_ready) begin
                exp_q.push_back(model(f, a, b));
                done = 1'b1;
            end else if (++wait_cycles > 200) begin
                checkOutput("accept_timeout", 32'd0, 32'd1);
                done = 1'b1;
            end
        end
        @(posedge Clk);
        #1;
        in_valid = 1'b0;
        func3    = 3'($urandom);
        data_a   = $urandom;
        data_b   = $urandom;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge Clk);
            n++;
        end
        if (exp_q.size() != 0) checkOutput("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(posedge Clk);
        #1;
    endtask

    task automatic fastOp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [35:0] e;
        e          = model(f, a, b);
        f_func3    = f;
        f_data_a   = a;
        f_data_b   = b;
        f_in_valid = 1'b1;
        @(negedge Clk);
        checkOutput("fast_in_ready", 32'(f_in_ready), 32'd1);
        @(posedge Clk);
        #1;
        f_in_valid = 1'b0;
        @(negedge Clk);
        checkOutput("fast_valid", 32'(f_out_valid), 32'd1);
        checkOutput("fast_result", f_result_c, e[31:0]);
        checkOutput("fast_status", 32'(f_status), 32'(e[35:32]));
        @(posedge Clk);
        #1;
    endtask

    // Scoreboard: every completed output handshake pops one expectation.
    initial begin
        logic [35:0] e;
        forever begin
            @(negedge Clk);
            if (Rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("result", result_c, e[31:0]);
                    checkOutput("status", 32'(status), 32'(e[35:32]));
                end
            end
        end
    end

    // Random backpressure on the consumer side while enabled.
    initial begin
        forever begin
            @(posedge Clk);
            #1;
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        Rst_n       = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        func3       = 3'd0;
        data_a      = '0;
        data_b      = '0;
        f_in_valid  = 1'b0;
        f_out_ready = 1'b1;
        f_func3     = 3'd0;
        f_data_a    = '0;
        f_data_b    = '0;

        #3 Rst_n = 1'b0;
        #4;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_result", result_c, 32'd0);
        checkOutput("reset_status", 32'(status), 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

        // Directed arithmetic and shift vectors, back to back.
        applyStimulus(3'b000, 32'hFFFF_FFFF, 32'h1);
        applyStimulus(3'b001, 32'h8000_0000, 32'h1);
        applyStimulus(3'b001, 32'h0, 32'h1);
        applyStimulus(3'b111, 32'h1, 32'd31);
        applyStimulus(3'b100, 32'hF0F0_0000, 32'h0F0F_0000);
        applyStimulus(3'b000, 32'h7FFF_FFFF, 32'h1);
        waitDrain();

        // Shift amount zero completes in one cycle.
        applyStimulus(3'b111, 32'h3, 32'h0);
        @(negedge Clk);
        checkOutput("shamt0_latency", 32'(out_valid), 32'd1);
        @(posedge Clk);
        #1;
        waitDrain();

        // Iterative SRL by 4: busy for 4 cycles, valid on the 5th.
        applyStimulus(3'b110, 32'h8000_0001, 32'd4);
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            checkOutput("srl_busy_in_ready", 32'(in_ready), 32'd0);
            checkOutput("srl_busy_out_valid", 32'(out_valid), 32'd0);
        end
        @(negedge Clk);
        checkOutput("srl_latency", 32'(out_valid), 32'd1);
        @(posedge Clk);
        #1;
        waitDrain();

        // Backpressure: result held, no accept, then retire + accept together.
        out_ready = 1'b0;
        applyStimulus(3'b000, 32'h1234_5678, 32'h1111_1111);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_result", result_c, 32'h2345_6789);
            checkOutput("bp_status", 32'(status), 32'd0);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge Clk);
        #1;
        out_ready = 1'b1;
        applyStimulus(3'b101, 32'hFF00_FF00, 32'h0FF0_0FF0);
        @(negedge Clk);
        checkOutput("no_bubble", 32'(out_valid), 32'd1);
        @(posedge Clk);
        #1;
        waitDrain();

        // Random ops under random consumer backpressure.
        rand_bp = 1'b1;
        for (int i = 0; i < 24; i++) begin
            applyStimulus(3'($urandom_range(0, 7)), $urandom, $urandom);
        end
        rand_bp   = 1'b0;
        out_ready = 1'b1;
        waitDrain();

        // Reset in the middle of an SLL by 8, when the counter reads 3.
        applyStimulus(3'b111, 32'h1, 32'd8);
        repeat (5) @(posedge Clk);
        #2;
        Rst_n = 1'b0;
        exp_q.delete();
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_result", result_c, 32'd0);
        checkOutput("midrst_status", 32'(status), 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        applyStimulus(3'b000, 32'd2, 32'd3);
        waitDrain();

        // Single-cycle barrel shifts.
        fastOp(3'b111, 32'h3, 32'd2);
        fastOp(3'b110, 32'h8000_0001, 32'd4);
        fastOp(3'b110, 32'h0000_00F0, 32'd5);
        fastOp(3'b111, 32'h8000_0001, 32'd1);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
